// File: rtl/reg_transfer_sequencer_pkg.sv
// Shared types and helpers for the register-bus transfer sequencer.
package bpu_regbus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        FINISH
    } seq_state_t;

    // Widest one-hot vector the decode helper can produce.
    localparam int unsigned ONEHOT_MAX = 64;

    // Bits needed to hold an index in [0, n-1]; never less than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // One-hot decode; out-of-range indices decode to all zeros.
    function automatic logic [ONEHOT_MAX-1:0] onehot(input int unsigned idx);
        logic [ONEHOT_MAX-1:0] v;
        v = '0;
        if (idx < ONEHOT_MAX) begin
            v[idx] = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/reg_transfer_sequencer_if.sv
// Requester handshake and register-file strobes of the transfer sequencer.
interface reg_transfer_sequencer_if
    import bpu_regbus_pkg::*;
#(
    parameter int unsigned NREG  = 8,
    parameter int unsigned NREQ  = 2,
    parameter int unsigned IDX_W = idx_width(NREG)
);
    logic [NREQ-1:0]       req;
    logic [NREQ*IDX_W-1:0] req_src;
    logic [NREQ*IDX_W-1:0] req_dst;
    logic [NREQ-1:0]       done;
    logic                  err;
    logic                  busy;
    logic [NREG-1:0]       reg_read;
    logic [NREG-1:0]       reg_write;

    // Sequencer side.
    modport slave (
        input  req, req_src, req_dst,
        output done, err, busy, reg_read, reg_write
    );

    // Requester / register-file side.
    modport master (
        output req, req_src, req_dst,
        input  done, err, busy, reg_read, reg_write
    );
endinterface

// File: rtl/reg_transfer_sequencer_arbiter.sv
// Combinational round-robin arbiter; the caller registers the grant.
module rr_arbiter
    import bpu_regbus_pkg::*;
#(
    parameter int unsigned N  = 2,
    parameter int unsigned GW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [GW-1:0] last_grant,
    output logic          valid,
    output logic [GW-1:0] grant
);

    logic [GW-1:0] cand;

    // Scan from the slot after the last winner with wrap-around; the last winner is tried last.
    always_comb begin
        valid = 1'b0;
        grant = '0;
        cand  = '0;
        for (int unsigned i = 1; i <= N; i++) begin
            cand = GW'((32'(last_grant) + i) % N);
            if (!valid && req[cand]) begin
                valid = 1'b1;
                grant = cand;
            end
        end
    end

endmodule

// File: rtl/reg_transfer_sequencer.sv
// Round-robin register-to-register move sequencer with flopped, glitch-free strobes.
module reg_transfer_sequencer
    import bpu_regbus_pkg::*;
#(
    parameter int unsigned NREG      = 8,
    parameter int unsigned NREQ      = 2,
    parameter int unsigned IDX_W     = idx_width(NREG),
    parameter int unsigned SETUP_CYC = 1
) (
    input  logic clk,
    input  logic rst_n,
    reg_transfer_sequencer_if.slave bus
);

    localparam int unsigned GW = idx_width(NREQ);
    localparam int unsigned CW = idx_width(SETUP_CYC);

    seq_state_t       state, state_nxt;

    logic [GW-1:0]    last_grant;
    logic [GW-1:0]    winner, winner_nxt;
    logic [IDX_W-1:0] src, src_nxt;
    logic [IDX_W-1:0] dst, dst_nxt;
    logic             rej, rej_nxt;
    logic             pend, pend_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;

    logic             arb_valid;
    logic [GW-1:0]    arb_grant;

    logic [IDX_W-1:0] src_in [NREQ];
    logic [IDX_W-1:0] dst_in [NREQ];

    logic [NREG-1:0]  read_q, read_nxt;
    logic [NREG-1:0]  write_q, write_nxt;
    logic [NREQ-1:0]  done_q, done_nxt;
    logic             err_q, err_nxt;
    logic             busy_q, busy_nxt;

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign src_in[i] = bus.req_src[i*IDX_W +: IDX_W];
        assign dst_in[i] = bus.req_dst[i*IDX_W +: IDX_W];
    end

    function automatic logic is_reject(input logic [IDX_W-1:0] s, input logic [IDX_W-1:0] d);
        return (32'(s) >= NREG) || (32'(d) >= NREG) || (s == d);
    endfunction

    rr_arbiter #(
        .N  (NREQ),
        .GW (GW)
    ) u_arb (
        .req        (bus.req),
        .last_grant (last_grant),
        .valid      (arb_valid),
        .grant      (arb_grant)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, plus request capture in IDLE and the setup countdown.
    // A rejected move spends two cycles in FINISH (pend set on entry) so that
    // done/err land one cycle after the busy cycle with no bus activity.
    always_comb begin
        state_nxt  = state;
        winner_nxt = winner;
        src_nxt    = src;
        dst_nxt    = dst;
        rej_nxt    = rej;
        pend_nxt   = pend;
        cnt_nxt    = cnt;
        unique case (state)
            IDLE: begin
                if (arb_valid) begin
                    winner_nxt = arb_grant;
                    src_nxt    = src_in[arb_grant];
                    dst_nxt    = dst_in[arb_grant];
                    rej_nxt    = is_reject(src_in[arb_grant], dst_in[arb_grant]);
                    if (rej_nxt) begin
                        state_nxt = FINISH;
                        pend_nxt  = 1'b1;
                    end else begin
                        state_nxt = SETUP;
                        cnt_nxt   = CW'(SETUP_CYC - 1);
                    end
                end
            end
            SETUP: begin
                if (cnt == '0) begin
                    state_nxt = STROBE;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            STROBE: state_nxt = HOLD;
            HOLD:   state_nxt = FINISH;
            FINISH: begin
                if (pend) begin
                    pend_nxt = 1'b0;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from the upcoming state so every output leaves a flop.
    always_comb begin
        read_nxt  = '0;
        write_nxt = '0;
        done_nxt  = '0;
        err_nxt   = 1'b0;
        busy_nxt  = (state_nxt != IDLE);
        unique case (state_nxt)
            SETUP, HOLD: read_nxt = NREG'(onehot(32'(src_nxt)));
            STROBE: begin
                read_nxt  = NREG'(onehot(32'(src_nxt)));
                write_nxt = NREG'(onehot(32'(dst_nxt)));
            end
            FINISH: begin
                if (!pend_nxt) begin
                    done_nxt = NREQ'(onehot(32'(winner_nxt)));
                    err_nxt  = rej_nxt;
                end
            end
            default: ;
        endcase
    end

    // Transfer context and round-robin pointer; pointer reset gives requester 0 priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= GW'(NREQ - 1);
            winner     <= '0;
            src        <= '0;
            dst        <= '0;
            rej        <= 1'b0;
            pend       <= 1'b0;
            cnt        <= '0;
        end else begin
            winner <= winner_nxt;
            src    <= src_nxt;
            dst    <= dst_nxt;
            rej    <= rej_nxt;
            pend   <= pend_nxt;
            cnt    <= cnt_nxt;
            if (state == FINISH && state_nxt == IDLE) begin
                last_grant <= winner;
            end
        end
    end

    // Output flops; reg_write clocks the registers so it must never come from logic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            read_q  <= '0;
            write_q <= '0;
            done_q  <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            read_q  <= read_nxt;
            write_q <= write_nxt;
            done_q  <= done_nxt;
            err_q   <= err_nxt;
            busy_q  <= busy_nxt;
        end
    end

    assign bus.reg_read  = read_q;
    assign bus.reg_write = write_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.busy      = busy_q;

endmodule
